// File: rtl/pito_pkg.sv
// Shared types and constants for the pito interrupt controller.
// The mcause codes, CSR addresses and the controller state type live here.
package pito_pkg;

    // CSR address space (12-bit RISC-V CSR numbers)
    typedef logic [11:0] csr_t;

    localparam csr_t CSR_MSTATUS = 12'h300;
    localparam csr_t CSR_MIE     = 12'h304;
    localparam csr_t CSR_MTVEC   = 12'h305;
    localparam csr_t CSR_MEPC    = 12'h341;
    localparam csr_t CSR_MCAUSE  = 12'h342;
    localparam csr_t CSR_MIP     = 12'h344;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'd0,
        CSR_READ  = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_t;

    // mcause interrupt codes (low bits of mcause, MSB marks an interrupt)
    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MEI = 11;
    localparam int unsigned IRQ_MVU = 16;

    // Default code per line, index 3..0
    localparam logic [3:0][4:0] IRQ_CODE_DEFAULT = {
        5'(IRQ_MVU), 5'(IRQ_MEI), 5'(IRQ_MTI), 5'(IRQ_MSI)
    };

    // Depth of the serviced-index stack when nesting is built in
    localparam int unsigned IRQ_STACK_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } irq_state_t;

    // mcause value for an interrupt with the given code
    function automatic logic [31:0] irq_cause(input logic [4:0] code);
        return {1'b1, 26'd0, code};
    endfunction

endpackage

// File: rtl/pito_irq_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any request is set
// and the index of the lowest set request.
module pito_irq_prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        valid_o = |req_i;
        index_o = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pito_irq_ctrl.sv
// Machine-mode interrupt controller for pito: per-line enables (MIE),
// pending view (MIP), sticky edge capture and a trap request handshake.
// Optional macro PITO_IRQ_NEST_EN allows a higher-priority (lower index)
// line to preempt a handler, tracked on a small stack of serviced indices.
module pito_irq_ctrl
    import pito_pkg::*;
#(
    parameter int unsigned               NUM_IRQ   = 4,
    parameter logic [NUM_IRQ-1:0][4:0]   IRQ_CODE  = IRQ_CODE_DEFAULT,
    parameter logic [NUM_IRQ-1:0]        EDGE_MASK = 4'b1000
) (
    input  logic               pito_io_clk,
    input  logic               pito_io_rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               mstatus_mie_i,
    input  logic               csr_we_i,
    input  csr_op_t            csr_op_i,
    input  csr_t               csr_addr_i,
    input  logic [31:0]        csr_wdata_i,
    output logic [31:0]        csr_rdata_o,
    output logic               trap_req_o,
    output logic [31:0]        trap_cause_o,
    input  logic               trap_ack_i,
    input  logic               mret_i
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] ie_q, ie_d;
    logic [NUM_IRQ-1:0] pend_edge_q, pend_edge_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending, active, rise, wr_bits, mip_clr, ack_clr;
    logic               mie_hit, mip_hit;
    irq_state_t         state_q, state_d;
    logic [31:0]        cause_q, cause_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               enc_valid;
    logic [IDX_W-1:0]   enc_idx;

    // Only the mapped code bits of the operand are ever used
    logic unused_wdata;
    assign unused_wdata = ^csr_wdata_i;

    assign mie_hit = csr_we_i && (csr_addr_i == CSR_MIE);
    assign mip_hit = csr_we_i && (csr_addr_i == CSR_MIP);

    assign rise    = irq_i & ~irq_q & EDGE_MASK;
    assign pending = (irq_i & ~EDGE_MASK) | (pend_edge_q & EDGE_MASK);
    assign active  = pending & ie_q;

    // Gather the operand bit that belongs to each line
    always_comb begin
        wr_bits = '0;
        for (int k = 0; k < int'(NUM_IRQ); k++) begin
            wr_bits[k] = csr_wdata_i[IRQ_CODE[k]];
        end
    end

    // Enable register update from CSR_MIE accesses
    always_comb begin
        ie_d = ie_q;
        if (mie_hit) begin
            case (csr_op_i)
                CSR_WRITE: ie_d = wr_bits;
                CSR_SET:   ie_d = ie_q | wr_bits;
                CSR_CLEAR: ie_d = ie_q & ~wr_bits;
                default:   ie_d = ie_q;
            endcase
        end
    end

    // Edge pending clears: software via MIP, hardware on trap acceptance
    always_comb begin
        mip_clr = '0;
        ack_clr = '0;
        if (mip_hit) begin
            if (csr_op_i == CSR_WRITE) begin
                mip_clr = EDGE_MASK & ~wr_bits;
            end else if (csr_op_i == CSR_CLEAR) begin
                mip_clr = EDGE_MASK & wr_bits;
            end
        end
        if ((state_q == StReq) && trap_ack_i) begin
            ack_clr[idx_q] = EDGE_MASK[idx_q];
        end
        // A new rising edge wins over any clear in the same cycle
        pend_edge_d = (pend_edge_q & ~(mip_clr | ack_clr)) | rise;
    end

    // CSR read mux, driven from current register state
    always_comb begin
        csr_rdata_o = '0;
        if (csr_we_i) begin
            for (int k = 0; k < int'(NUM_IRQ); k++) begin
                if (csr_addr_i == CSR_MIE) begin
                    csr_rdata_o[IRQ_CODE[k]] = ie_q[k];
                end else if (csr_addr_i == CSR_MIP) begin
                    csr_rdata_o[IRQ_CODE[k]] = pending[k];
                end
            end
        end
    end

    pito_irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i   (active),
        .valid_o (enc_valid),
        .index_o (enc_idx)
    );

`ifdef PITO_IRQ_NEST_EN
    logic [IRQ_STACK_DEPTH-1:0][IDX_W-1:0] stack_q;
    logic [2:0]                            sp_q;
    logic [1:0]                            top_ptr;
    logic [IDX_W-1:0]                      top_idx;

    assign top_ptr = sp_q[1:0] - 2'd1;
    assign top_idx = stack_q[top_ptr];

    // Stack of serviced indices: push on acceptance, pop on return
    always_ff @(posedge pito_io_clk or negedge pito_io_rst_n) begin
        if (!pito_io_rst_n) begin
            stack_q <= '0;
            sp_q    <= '0;
        end else if ((state_q == StReq) && trap_ack_i &&
                     (sp_q < 3'(IRQ_STACK_DEPTH))) begin
            stack_q[sp_q[1:0]] <= idx_q;
            sp_q               <= sp_q + 3'd1;
        end else if ((state_q == StService) && mret_i && (sp_q != 3'd0)) begin
            sp_q <= sp_q - 3'd1;
        end
    end
`endif

    // Trap FSM next state; cause and index latch when a request is raised
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (mstatus_mie_i && enc_valid) begin
                    state_d = StReq;
                    cause_d = irq_cause(IRQ_CODE[enc_idx]);
                    idx_d   = enc_idx;
                end
            end
            StReq: begin
                if (trap_ack_i) begin
                    state_d = StService;
                end
            end
            StService: begin
`ifdef PITO_IRQ_NEST_EN
                if (mret_i) begin
                    if (sp_q <= 3'd1) begin
                        state_d = StIdle;
                    end
                end else if (mstatus_mie_i && enc_valid && (enc_idx < top_idx) &&
                             (sp_q < 3'(IRQ_STACK_DEPTH))) begin
                    state_d = StReq;
                    cause_d = irq_cause(IRQ_CODE[enc_idx]);
                    idx_d   = enc_idx;
                end
`else
                if (mret_i) begin
                    state_d = StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State, enable, pending and sampled-line registers
    always_ff @(posedge pito_io_clk or negedge pito_io_rst_n) begin
        if (!pito_io_rst_n) begin
            state_q     <= StIdle;
            cause_q     <= '0;
            idx_q       <= '0;
            ie_q        <= '0;
            pend_edge_q <= '0;
            irq_q       <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            idx_q       <= idx_d;
            ie_q        <= ie_d;
            pend_edge_q <= pend_edge_d;
            irq_q       <= irq_i;
        end
    end

    assign trap_req_o   = (state_q == StReq);
    assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_pito_irq_ctrl.sv
// Bench for pito_irq_ctrl: directed scenarios plus random traffic, checked
// by a scoreboard fed from a behavioural model of the controller.
module tb_pito_irq_ctrl;
    import pito_pkg::*;

    localparam int       CODE [4] = '{3, 7, 11, 16};
    localparam bit [3:0] EDGE     = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  irq_i = '0;
    logic        mstatus_mie_i = 1'b0;
    logic        csr_we_i = 1'b0;
    csr_op_t     csr_op_i = CSR_READ;
    csr_t        csr_addr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        trap_req_o;
    logic [31:0] trap_cause_o;
    logic        trap_ack_i = 1'b0;
    logic        mret_i = 1'b0;

    always #5 clk = ~clk;

    pito_irq_ctrl dut (
        .pito_io_clk   (clk),
        .pito_io_rst_n (rst_n),
        .irq_i         (irq_i),
        .mstatus_mie_i (mstatus_mie_i),
        .csr_we_i      (csr_we_i),
        .csr_op_i      (csr_op_i),
        .csr_addr_i    (csr_addr_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .trap_req_o    (trap_req_o),
        .trap_cause_o  (trap_cause_o),
        .trap_ack_i    (trap_ack_i),
        .mret_i        (mret_i)
    );

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t trap_q[$];
    exp_t rd_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // Model state: enables, sticky edge flags, previous lines, handshake phase
    bit [3:0]    m_ie, m_pend, m_prev;
    int          m_st;   // 0 waiting, 1 requesting, 2 in handler
    int          m_idx;
    logic [31:0] m_cause;

    bit [3:0] cur_irq = '0;
    bit       cur_mie = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] to_csr(input bit [3:0] b);
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++) if (b[k]) r = r | (32'h1 << CODE[k]);
        return r;
    endfunction

    function automatic bit [3:0] from_csr(input logic [31:0] w);
        bit [3:0] b = '0;
        for (int k = 0; k < 4; k++) b[k] = w[CODE[k]];
        return b;
    endfunction

    task automatic model_reset();
        m_ie = '0; m_pend = '0; m_prev = '0; m_st = 0; m_idx = 0; m_cause = '0;
    endtask

    // One clock cycle: apply inputs, queue expected outputs, advance the model
    task automatic drive(input bit [3:0] irq, input bit mie, input bit we, input csr_op_t op,
                         input csr_t addr, input logic [31:0] wd, input bit ack,
                         input bit mret, input logic [32:0] chk = '0);
        bit [3:0]    eff, wb, clr, rise, act, nie;
        logic [31:0] rd;
        exp_t        e;
        cyc++;
        irq_i = irq; mstatus_mie_i = mie; csr_we_i = we; csr_op_i = op;
        csr_addr_i = addr; csr_wdata_i = wd; trap_ack_i = ack; mret_i = mret;
        eff = (irq & ~EDGE) | (m_pend & EDGE);
        rd = '0;
        if (we && addr == CSR_MIE) rd = to_csr(m_ie);
        else if (we && addr == CSR_MIP) rd = to_csr(eff);
        e.cyc = cyc; e.val = rd; rd_q.push_back(e);
        if (m_st == 1) begin
            e.val = m_cause; trap_q.push_back(e);
        end
        if (chk[32]) begin
            #2;
            check("csr_rdata_const", csr_rdata_o, chk[31:0]);
        end
        @(posedge clk);
        wb = from_csr(wd);
        clr = '0;
        if (we && addr == CSR_MIP && op == CSR_WRITE) clr = EDGE & ~wb;
        if (we && addr == CSR_MIP && op == CSR_CLEAR) clr = EDGE & wb;
        nie = m_ie;
        if (we && addr == CSR_MIE && op == CSR_WRITE) nie = wb;
        if (we && addr == CSR_MIE && op == CSR_SET) nie = m_ie | wb;
        if (we && addr == CSR_MIE && op == CSR_CLEAR) nie = m_ie & ~wb;
        rise = irq & ~m_prev & EDGE;
        act = eff & m_ie;
        case (m_st)
            0: if (mie && act != 0) begin
                m_idx = 4;
                for (int k = 3; k >= 0; k--) if (act[k]) m_idx = k;
                m_cause = 32'h8000_0000 | 32'(CODE[m_idx]);
                m_st = 1;
            end
            1: if (ack) begin
                m_st = 2;
                if (EDGE[m_idx]) clr[m_idx] = 1'b1;
            end
            default: if (mret) m_st = 0;
        endcase
        m_pend = (m_pend & ~clr) | rise;
        m_prev = irq;
        m_ie = nie;
        #1;
    endtask

    task automatic step(input bit ack = 0, input bit mret = 0);
        drive(cur_irq, cur_mie, 1'b0, CSR_READ, CSR_MSTATUS, '0, ack, mret);
    endtask

    task automatic csr(input csr_op_t op, input csr_t addr, input logic [31:0] wd,
                       input logic [32:0] chk = '0);
        drive(cur_irq, cur_mie, 1'b1, op, addr, wd, 1'b0, 1'b0, chk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        irq_i = '0; mstatus_mie_i = 1'b0; csr_we_i = 1'b0; trap_ack_i = 1'b0; mret_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        cur_irq = '0;
        cur_mie = 1'b1;
    endtask

    // Monitor: pops expectations for the current cycle and compares them
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                    e = rd_q.pop_front();
                    check("csr_rdata", csr_rdata_o, e.val);
                end
                if (trap_q.size() > 0 && trap_q[0].cyc == cyc) begin
                    e = trap_q.pop_front();
                    check("trap_req", {31'd0, trap_req_o}, 32'd1);
                    check("trap_cause", trap_cause_o, e.val);
                end else if (trap_req_o !== 1'b0) begin
                    check("trap_req_idle", {31'd0, trap_req_o}, 32'd0);
                end
            end
        end
    end

    initial begin
        bit [3:0]    irq;
        bit          ack, mret, we, mie;
        csr_op_t     op;
        csr_t        addr;
        logic [31:0] wd;
        int          sel;

        model_reset();
        do_reset();
        check("rst_trap_req", {31'd0, trap_req_o}, 32'd0);
        check("rst_trap_cause", trap_cause_o, 32'd0);
        csr(CSR_READ, CSR_MIE, '0, {1'b1, 32'h0});

        // Level line 1 traps one cycle after it rises
        csr(CSR_WRITE, CSR_MIE, 32'h0001_0888);
        cur_irq = 4'b0010;
        step();
        check("lvl_req", {31'd0, trap_req_o}, 32'd1);
        check("lvl_cause", trap_cause_o, 32'h8000_0007);
        cur_irq = 4'b0000;
        step(1, 0);
        step(0, 1);
        step();

        // Edge pulse on line 3: sticky pending, cleared by acceptance
        cur_irq = 4'b1000;
        step();
        cur_irq = 4'b0000;
        csr(CSR_READ, CSR_MIP, '0, {1'b1, 32'h0001_0000});
        check("edge_req", {31'd0, trap_req_o}, 32'd1);
        check("edge_cause", trap_cause_o, 32'h8000_0010);
        step(1, 0);
        csr(CSR_READ, CSR_MIP, '0, {1'b1, 32'h0});
        step(0, 1);

        // Two lines at once: lowest index first, then the next
        cur_irq = 4'b0101;
        step();
        check("prio_cause0", trap_cause_o, 32'h8000_0003);
        step(1, 0);
        cur_irq = 4'b0100;
        step(0, 1);
        step();
        check("prio_cause2", trap_cause_o, 32'h8000_000B);
        cur_irq = 4'b0000;
        step(1, 0);
        step(0, 1);

        // Request must hold even after the line drops and MIE is cleared
        cur_irq = 4'b0010;
        step();
        cur_irq = 4'b0000;
        csr(CSR_WRITE, CSR_MIE, 32'h0);
        step();
        step();
        check("hold_req", {31'd0, trap_req_o}, 32'd1);
        check("hold_cause", trap_cause_o, 32'h8000_0007);
        step(1, 0);
        step(0, 1);

        // MIE set/clear and MIP write clearing edge state only
        csr(CSR_SET, CSR_MIE, 32'h800);
        csr(CSR_READ, CSR_MIE, '0, {1'b1, 32'h800});
        csr(CSR_CLEAR, CSR_MIE, 32'h800);
        csr(CSR_READ, CSR_MIE, '0, {1'b1, 32'h0});
        cur_mie = 1'b0;
        cur_irq = 4'b1001;
        step();
        cur_irq = 4'b0001;
        csr(CSR_READ, CSR_MIP, '0, {1'b1, 32'h0001_0008});
        csr(CSR_WRITE, CSR_MIP, 32'h0);
        csr(CSR_READ, CSR_MIP, '0, {1'b1, 32'h0000_0008});
        cur_irq = 4'b0000;
        step();
        cur_mie = 1'b1;

        // Asynchronous reset while requesting
        csr(CSR_WRITE, CSR_MIE, 32'h0001_0888);
        cur_irq = 4'b0010;
        step();
        check("pre_rst_req", {31'd0, trap_req_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, trap_req_o}, 32'd0);
        check("async_rst_cause", trap_cause_o, 32'd0);
        csr_we_i = 1'b1; csr_op_i = CSR_READ; csr_addr_i = CSR_MIE;
        #1;
        check("async_rst_mie", csr_rdata_o, 32'd0);
        do_reset();
        csr(CSR_READ, CSR_MIE, '0, {1'b1, 32'h0});
        step();

        // Random traffic
        csr(CSR_WRITE, CSR_MIE, 32'h0001_0888);
        for (int i = 0; i < 3000; i++) begin
            irq = cur_irq;
            for (int k = 0; k < 3; k++) if ($urandom_range(7) == 0) irq[k] = ~irq[k];
            irq[3] = ($urandom_range(5) == 0);
            mie = ($urandom_range(7) != 0);
            ack = (m_st == 1) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
            mret = (m_st == 2) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
            we = ($urandom_range(2) == 0);
            op = csr_op_t'($urandom_range(3));
            sel = $urandom_range(4);
            addr = (sel < 2) ? CSR_MIE : (sel < 4) ? CSR_MIP : CSR_MSTATUS;
            wd = $urandom();
            if ($urandom_range(1) == 1) wd = wd & 32'h0001_0888;
            drive(irq, mie, we, op, addr, wd, ack, mret);
            cur_irq = irq;
        end
        step();

        if (trap_q.size() != 0) check("trap_left", 32'(trap_q.size()), 32'd0);
        if (rd_q.size() != 0) check("rdata_left", 32'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
